// File: rtl/stair_counter_pkg.sv
// Shared constants and helpers for the staircase counter.
package stair_counter_pkg;

  localparam int STAIR_WIDTH_DEF = 3;

  function automatic int stair_max(input int width);
    return (1 << width) - 1;
  endfunction

  // Cycles for one full staircase 1..max_val, each value held for itself.
  function automatic int stair_period(input int max_val);
    return max_val * (max_val + 1) / 2;
  endfunction

endpackage

// File: rtl/stair_rep_cnt.sv
// Repeat counter: counts cycles spent at the current staircase value (1-based).
module stair_rep_cnt
  import stair_counter_pkg::*;
#(
  parameter int WIDTH = STAIR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] rep,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign done = (rep == limit);

  // rep >= limit also covers rep > limit and limit == 0, which recover to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rep <= ONE;
    else if (rep >= limit)
      rep <= ONE;
    else
      rep <= rep + ONE;
  end

endmodule

// File: rtl/stair_counter.sv
// Free-running staircase counter: value v is held v cycles, wraps MAX_VAL -> 1.
// Optional registered wrap pulse when STAIR_COUNTER_WRAP_FLAG_EN is defined.
module stair_counter
  import stair_counter_pkg::*;
#(
  parameter int WIDTH   = STAIR_WIDTH_DEF,
  parameter int MAX_VAL = stair_max(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] rep;
  logic [WIDTH-1:0] count_nxt;
  logic             done;
  logic             illegal;
  logic             at_top;

  stair_rep_cnt #(.WIDTH(WIDTH)) u_rep (
    .clk   (clk),
    .rst   (rst),
    .limit (count),
    .rep   (rep),
    .done  (done)
  );

  assign illegal = (count == '0) || (rep > count);
  // Values above MAX_VAL are clamped back to 1 the same way a normal wrap is.
  assign at_top  = (count >= MAX_L);

  always_comb begin
    count_nxt = count;
    if (illegal)
      count_nxt = ONE;
    else if (done)
      count_nxt = at_top ? ONE : count + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= ONE;
    else
      count <= count_nxt;
  end

`ifdef STAIR_COUNTER_WRAP_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wrap <= 1'b0;
    else
      wrap <= done && (count == MAX_L);
  end
`else
`endif

endmodule

// File: tb/tb_stair_counter.sv
// Scoreboard bench for stair_counter: default, WIDTH=2 and WIDTH=3/MAX_VAL=4 instances.
module tb_stair_counter;
  import stair_counter_pkg::*;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count_a;
  logic [1:0] count_b;
  logic [2:0] count_c;
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
  logic       wrap_a, wrap_b, wrap_c;
`endif

  int checks   = 0;
  int failures = 0;
  iq_t seq_a, seq_b, seq_c;
  int idx_a, idx_b, idx_c;
  int exp_q[$];
  int zero_seen = 0;
  int wrap_cnt  = 0;

  always #5 clk = ~clk;

  stair_counter u_a (
    .clk   (clk),
    .rst   (rst),
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    .wrap  (wrap_a),
`endif
    .count (count_a)
  );

  stair_counter #(.WIDTH(2)) u_b (
    .clk   (clk),
    .rst   (rst),
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    .wrap  (wrap_b),
`endif
    .count (count_b)
  );

  stair_counter #(.WIDTH(3), .MAX_VAL(4)) u_c (
    .clk   (clk),
    .rst   (rst),
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    .wrap  (wrap_c),
`endif
    .count (count_c)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference staircase for one period: 1, 2,2, 3,3,3, ...
  function automatic iq_t build(input int max_v);
    iq_t q;
    for (int v = 1; v <= max_v; v++)
      for (int r = 0; r < v; r++)
        q.push_back(v);
    return q;
  endfunction

  task automatic step();
    idx_a = (idx_a + 1) % seq_a.size();
    idx_b = (idx_b + 1) % seq_b.size();
    idx_c = (idx_c + 1) % seq_c.size();
    exp_q.push_back(seq_a[idx_a]);
    exp_q.push_back(seq_b[idx_b]);
    exp_q.push_back(seq_c[idx_c]);
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    exp_q.push_back(idx_a == 0 ? 1 : 0);
    exp_q.push_back(idx_b == 0 ? 1 : 0);
    exp_q.push_back(idx_c == 0 ? 1 : 0);
`endif
    @(posedge clk);
    #5;
    check_val("count_a", 32'(count_a), exp_q.pop_front());
    check_val("count_b", 32'(count_b), exp_q.pop_front());
    check_val("count_c", 32'(count_c), exp_q.pop_front());
    if (count_a == '0) zero_seen++;
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    check_val("wrap_a", 32'(wrap_a), exp_q.pop_front());
    check_val("wrap_b", 32'(wrap_b), exp_q.pop_front());
    check_val("wrap_c", 32'(wrap_c), exp_q.pop_front());
    if (wrap_a) wrap_cnt++;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_a"}, 32'(count_a), 1);
    check_val({tag, "_b"}, 32'(count_b), 1);
    check_val({tag, "_c"}, 32'(count_c), 1);
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    check_val({tag, "_wrap_a"}, 32'(wrap_a), 0);
`endif
  endtask

  initial begin
    seq_a = build(stair_max(3));
    seq_b = build(stair_max(2));
    seq_c = build(4);
    idx_a = 0;
    idx_b = 0;
    idx_c = 0;
    rst   = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #5;
      check_reset_state("reset_hold");
    end
    rst = 1'b0;

    for (int i = 0; i < 5 * stair_period(stair_max(3)); i++)
      step();
    check_val("never_zero", 32'(zero_seen), 0);
`ifdef STAIR_COUNTER_WRAP_FLAG_EN
    check_val("wrap_count", 32'(wrap_cnt), 5);
`endif

    // Advance to the first cycle at value 5, then reset between edges.
    for (int i = 0; i < 10; i++)
      step();
    check_val("pre_async_a", 32'(count_a), 5);
    #1 rst = 1'b1;
    #1 check_reset_state("async_rst");
    #1 rst = 1'b0;
    idx_a = 0;
    idx_b = 0;
    idx_c = 0;
    for (int i = 0; i < stair_period(stair_max(3)); i++)
      step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
